// File: rtl/sa_vlib_pkg.sv
// Shared definitions for the small-config vlib reducers: legal parameter
// ranges and the per-bit-column masked reduction primitive.
package sa_vlib_pkg;

  localparam int DW_MIN     = 1;
  localparam int DW_MAX     = 64;
  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Masked-off channels (and zero-padded upper channels) read as ones, so they
  // never pull the AND low.
  function automatic logic masked_and_col(input logic [NUM_IN_MAX-1:0] col,
                                          input logic [NUM_IN_MAX-1:0] mask);
    return &(col | ~mask);
  endfunction

endpackage

// File: rtl/sa_pipe_stage.sv
// One elastic valid/ready register stage; an empty stage accepts even when
// downstream stalls, so bubbles collapse.
module sa_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_pd,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_pd
);

  assign up_rdy = ~dn_vld | dn_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
    end
  end

  // Payload only moves with a real beat, so bubbles cause no data toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_pd <= '0;
    end else if (up_rdy && up_vld) begin
      dn_pd <= up_pd;
    end
  end

endmodule

// File: rtl/sa_and_reduce_pipe.sv
// Masked bitwise AND (optionally NAND) across NUM_IN channels, retimed through
// a STAGES-deep elastic pipeline. in_prdy is combinational from out_prdy.
module sa_and_reduce_pipe
  import sa_vlib_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NUM_IN = 4,
  parameter int STAGES = 2
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 in_pvld,
  output logic                 in_prdy,
  input  logic [NUM_IN*DW-1:0] in_pd,
  input  logic [NUM_IN-1:0]    in_mask,
  input  logic                 cfg_inv,
  output logic                 out_pvld,
  input  logic                 out_prdy,
  output logic [DW-1:0]        out_pd,
  output logic                 out_zero
);

  if (DW < DW_MIN || DW > DW_MAX) begin : g_bad_dw
    $error("sa_and_reduce_pipe: DW out of range");
  end
  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("sa_and_reduce_pipe: NUM_IN out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sa_and_reduce_pipe: STAGES out of range");
  end

  // Payload carries a nonzero flag rather than a zero flag so that an all-zero
  // reset state still presents out_zero=1.
  localparam int PW = DW + 1;

  logic [DW-1:0] red_and;
  logic [DW-1:0] red_r;
  logic          red_nz;

  for (genvar b = 0; b < DW; b++) begin : g_col
    logic [NUM_IN-1:0] col;
    for (genvar k = 0; k < NUM_IN; k++) begin : g_ch
      assign col[k] = in_pd[k*DW + b];
    end
    assign red_and[b] = masked_and_col(NUM_IN_MAX'(col), NUM_IN_MAX'(in_mask));
  end

  assign red_r  = red_and ^ {DW{cfg_inv}};
  assign red_nz = |red_r;

  logic          vld_c [STAGES+1];
  logic          rdy_c [STAGES+1];
  logic [PW-1:0] pd_c  [STAGES+1];

  assign vld_c[0]      = in_pvld;
  assign pd_c[0]       = {red_nz, red_r};
  assign rdy_c[STAGES] = out_prdy;

  // Stage boundaries: element i of each chain is the input side of stage i.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    sa_pipe_stage #(.W(PW)) u_stage (
      .clk    (nvdla_core_clk),
      .rst_n  (nvdla_core_rstn),
      .up_vld (vld_c[i]),
      .up_rdy (rdy_c[i]),
      .up_pd  (pd_c[i]),
      .dn_vld (vld_c[i+1]),
      .dn_rdy (rdy_c[i+1]),
      .dn_pd  (pd_c[i+1])
    );
  end

  assign in_prdy  = rdy_c[0];
  assign out_pvld = vld_c[STAGES];
  assign out_pd   = pd_c[STAGES][DW-1:0];
  assign out_zero = ~pd_c[STAGES][DW];

endmodule

// File: tb/tb_sa_and_reduce_pipe.sv
// Bench for sa_and_reduce_pipe (DW=8, NUM_IN=4, STAGES=2): directed cases plus
// randomized traffic scored against a queue-based reference.
module tb_sa_and_reduce_pipe;

  localparam int DW     = 8;
  localparam int NUM_IN = 4;
  localparam int STAGES = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_pvld = 1'b0;
  logic                 in_prdy;
  logic [NUM_IN*DW-1:0] in_pd = '0;
  logic [NUM_IN-1:0]    in_mask = '0;
  logic                 cfg_inv = 1'b0;
  logic                 out_pvld;
  logic                 out_prdy = 1'b1;
  logic [DW-1:0]        out_pd;
  logic                 out_zero;

  sa_and_reduce_pipe #(.DW(DW), .NUM_IN(NUM_IN), .STAGES(STAGES)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_pd           (in_pd),
    .in_mask         (in_mask),
    .cfg_inv         (cfg_inv),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_pd          (out_pd),
    .out_zero        (out_zero)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int popped   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_and(input logic [NUM_IN*DW-1:0] pd,
                                            input logic [NUM_IN-1:0] m,
                                            input logic inv);
    logic [DW-1:0] r;
    r = '1;
    for (int k = 0; k < NUM_IN; k++)
      if (m[k]) r = r & pd[k*DW +: DW];
    return inv ? ~r : r;
  endfunction

  typedef struct {
    logic [DW-1:0] pd;
    logic          z;
  } beat_t;

  beat_t q[$];

  logic          hold_prev = 1'b0;
  logic [DW-1:0] held_pd;
  logic          held_z;

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    beat_t e;
    beat_t n;
    if (!rstn) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_vld", out_pvld, 1'b1);
        check("hold_pd", out_pd, held_pd);
        check("hold_zero", out_zero, held_z);
      end
      if (out_pvld && out_prdy) begin
        if (q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("out_pd", out_pd, e.pd);
          check("out_zero", out_zero, e.z);
        end
        popped++;
      end
      hold_prev = out_pvld && !out_prdy;
      held_pd   = out_pd;
      held_z    = out_zero;
      if (in_pvld && in_prdy) begin
        n.pd = ref_and(in_pd, in_mask, cfg_inv);
        n.z  = (n.pd == '0);
        q.push_back(n);
      end
    end
  end

  task automatic set_beat(input logic [NUM_IN*DW-1:0] pd, input logic [NUM_IN-1:0] m,
                          input logic inv);
    in_pvld = 1'b1;
    in_pd   = pd;
    in_mask = m;
    cfg_inv = inv;
  endtask

  task automatic rand_beat();
    logic [NUM_IN*DW-1:0] pd;
    pd = $urandom | $urandom;
    if ($urandom_range(0, 9) == 0) pd = '0;
    set_beat(pd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check(name, q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [NUM_IN*DW-1:0] bp_pd [5];
  int acc;
  int pop0;

  initial begin
    // Reset state, sampled while reset is held.
    #3;
    check("rst_out_pvld", out_pvld, 1'b0);
    check("rst_out_pd", out_pd, 8'h00);
    check("rst_out_zero", out_zero, 1'b1);
    check("rst_in_prdy", in_prdy, 1'b1);
    #19 rstn = 1'b1;

    check("model_and", ref_and(32'hFFF03CFF, 4'b1111, 1'b0), 8'h30);
    check("model_nand", ref_and(32'h00AAFF0F, 4'b0110, 1'b1), 8'h55);
    check("model_nomask", ref_and(32'h00AAFF0F, 4'b0000, 1'b0), 8'hFF);
    check("model_nomask_inv", ref_and(32'h00AAFF0F, 4'b0000, 1'b1), 8'h00);

    // Single beat latency.
    @(posedge clk); #1;
    set_beat(32'hFFF03CFF, 4'b1111, 1'b0);
    @(posedge clk); #1;
    in_pvld = 1'b0;
    @(negedge clk);
    check("lat_early_vld", out_pvld, 1'b0);
    @(negedge clk);
    check("lat_vld", out_pvld, 1'b1);
    check("lat_pd", out_pd, 8'h30);
    check("lat_zero", out_zero, 1'b0);
    @(negedge clk);
    check("lat_single_pulse", out_pvld, 1'b0);
    @(posedge clk); #1;

    // Mask + invert, then all-masked, back to back.
    set_beat(32'h00AAFF0F, 4'b0110, 1'b1);
    @(posedge clk); #1;
    set_beat(32'h00AAFF0F, 4'b0000, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    in_pvld = 1'b0;
    @(negedge clk);
    check("nand_pd", out_pd, 8'h55);
    check("nand_vld", out_pvld, 1'b1);
    @(negedge clk);
    check("nomask_pd", out_pd, 8'hFF);
    check("nomask_zero", out_zero, 1'b0);
    drain("drain_directed");

    // Back-pressure: only STAGES beats fit while the sink stalls.
    for (int i = 0; i < 5; i++) bp_pd[i] = $urandom | $urandom;
    out_prdy = 1'b0;
    acc = 0;
    pop0 = popped;
    for (int cyc = 0; cyc < 6; cyc++) begin
      set_beat(bp_pd[acc], 4'b1011, 1'b0);
      @(negedge clk);
      if (in_prdy) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, STAGES);
    @(negedge clk);
    check("bp_in_prdy_full", in_prdy, 1'b0);
    check("bp_out_pvld", out_pvld, 1'b1);
    @(posedge clk); #1;
    out_prdy = 1'b1;
    for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
      set_beat(bp_pd[acc], 4'b1011, 1'b0);
      @(negedge clk);
      if (in_prdy) acc++;
      @(posedge clk); #1;
    end
    in_pvld = 1'b0;
    check("bp_all_accepted", acc, 5);
    drain("drain_bp");
    check("bp_all_emerged", popped - pop0, 5);

    // Full-pipe streaming: one beat per cycle, no gaps.
    pop0 = popped;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      @(negedge clk);
      check("stream_in_prdy", in_prdy, 1'b1);
      if (i >= STAGES) check("stream_no_gap", out_pvld, 1'b1);
      @(posedge clk); #1;
    end
    in_pvld = 1'b0;
    drain("drain_stream");
    check("stream_count", popped - pop0, 100);

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) rand_beat(); else in_pvld = 1'b0;
      out_prdy = 1'($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_pvld  = 1'b0;
    out_prdy = 1'b1;
    drain("drain_random");

    // Asynchronous reset with two beats in flight.
    set_beat(32'h12345678, 4'b1111, 1'b1);
    @(posedge clk); #1;
    set_beat(32'hFFFFFFFF, 4'b0001, 1'b0);
    @(posedge clk); #1;
    in_pvld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("arst_out_pvld", out_pvld, 1'b0);
    check("arst_out_pd", out_pd, 8'h00);
    check("arst_out_zero", out_zero, 1'b1);
    check("arst_in_prdy", in_prdy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    set_beat(32'hC3F0FF0F, 4'b1110, 1'b0);
    @(posedge clk); #1;
    in_pvld = 1'b0;
    @(negedge clk);
    check("post_rst_early", out_pvld, 1'b0);
    @(negedge clk);
    check("post_rst_vld", out_pvld, 1'b1);
    check("post_rst_pd", out_pd, 8'hC0);
    @(negedge clk);
    check("post_rst_no_residue", out_pvld, 1'b0);
    check("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_and_reduce_pipe.md
Name: sa_and_reduce_pipe

Overview:
- Parametrised successor to the 2-input AND library cell: a bitwise AND across NUM_IN channels of DW-bit operands.
- Supports a per-channel mask and an optional inverted (NAND) output.
- Result passes through a STAGES-deep elastic valid/ready pipeline.
- Used in the small-config vlibs wherever wide enable/mask reduction must be retimed across a register boundary with back-pressure.

Parameters:
- DW, 8, operand and result width in bits (1..64).
- NUM_IN, 4, number of input channels reduced (2..16).
- STAGES, 2, number of pipeline register stages (1..4). Equals latency with no stalls.

Ports:
- nvdla_core_clk  input  1  core clock, all flops rising-edge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- in_pvld  input  1  input beat valid.
- in_prdy  output  1  block can accept input beat.
- in_pd  input  NUM_IN*DW  operands; channel k occupies bits [k*DW +: DW].
- in_mask  input  NUM_IN  1 = channel participates; 0 = channel treated as all-ones. Sampled with in_pd.
- cfg_inv  input  1  1 = invert result (NAND). Sampled with in_pd on acceptance.
- out_pvld  output  1  result valid.
- out_prdy  input  1  downstream accepts result.
- out_pd  output  DW  reduced result.
- out_zero  output  1  out_pd == 0, aligned with out_pd.

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous, active-low.
- Reset values: all stage valid flops = 0, all data flops = 0. Hence out_pvld=0, out_pd=0, out_zero=1, in_prdy=1 immediately on reset assertion.
- Input accept: a beat is accepted when in_pvld && in_prdy.
- Function, combinational before stage 0:
  - r = AND over k of (in_pd[k] | {DW{~in_mask[k]}}).
  - If cfg_inv, r = ~r.
  - z = (r == 0).
  - in_mask all zero gives r = all-ones (or all-zeros if cfg_inv).
- Stage i (0..STAGES-1) holds vld_i, pd_i[DW], zero_i.
  - Stage i loads when its ready rdy_i = ~vld_i | rdy_{i+1}. rdy_STAGES = out_prdy.
  - Stage 0 loads from the input; stage i>0 loads from stage i-1.
  - vld_i next = rdy_i ? vld_{i-1} : vld_i, with vld_{-1} = in_pvld.
  - Data flops load only when rdy_i && upstream valid. They hold otherwise, so no toggling on bubbles.
- Outputs: in_prdy = rdy_0. out_pvld = vld_{STAGES-1}. out_pd = pd_{STAGES-1}. out_zero = zero_{STAGES-1}.
- Latency and throughput:
  - Accepted beat appears on out_pvld exactly STAGES cycles later if out_prdy is held 1.
  - Throughput 1 beat/cycle.
- Back-pressure:
  - out_prdy=0 with pipe full deasserts in_prdy combinationally in the same cycle.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
  - Capacity = STAGES beats.
- Simultaneous events:
  - Full pipe with out_prdy=1: output pops and input is accepted in the same cycle.
  - No beat is lost or duplicated.
- Stability: while out_pvld && !out_prdy, out_pd and out_zero stay constant.
- Reset mid-operation: in-flight beats are discarded. Outputs return to reset values asynchronously. First accept is possible on the first clock after deassertion.
- Combinational ready path: in_prdy depends combinationally on out_prdy; this is documented for integrators. No skid buffer in this block.
- No X propagation:
  - The function is purely bitwise; the width of r is DW.
  - in_pd and in_mask are don't-care when in_pvld=0.

Decomposition:
- Shared package/header sa_vlib_pkg:
  - Localparam checks: DW range, NUM_IN range, STAGES range. Elaboration error if violated.
  - Function for the masked AND reduction, reused by sibling OR/XOR reducers.
- One sub-module is natural: sa_pipe_stage (DW+1 payload, valid/ready, async active-low reset), instantiated STAGES times via generate.
- Reduction logic stays in the top.

Test Plan:
- Reset then idle, DW=8, NUM_IN=4, STAGES=2 -> out_pvld=0, out_pd=0x00, out_zero=1, in_prdy=1.
- Single beat: in_pd={0xFF,0xF0,0x3C,0xFF}, mask=4'b1111, cfg_inv=0, out_prdy=1 -> two cycles later out_pvld=1 for 1 cycle, out_pd=0x30, out_zero=0.
- Mask and invert:
  - in_pd={0x00,0xAA,0xFF,0x0F}, mask=4'b0110, cfg_inv=1 -> out_pd=~(0xAA&0xFF)=0x55.
  - Same beat with mask=0000, cfg_inv=0 -> 0xFF.
- Back-pressure:
  - Stream 5 beats, out_prdy=0 from cycle 1 -> exactly 2 accepted; in_prdy=0 while full.
  - Release out_prdy -> all 5 emerge in order, values unchanged while stalled.
- Full-pipe pass-through: pipe full and out_prdy=1 with in_pvld=1 continuously -> 1 beat/cycle, no gaps, no duplicates over 100 random beats checked against the reference model.
- Async reset mid-stream: assert nvdla_core_rstn=0 between clock edges with 2 beats in flight -> out_pvld drops to 0 immediately. After release, a new beat yields a correct result after STAGES cycles with no residue.
